// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared stage state, constants and boundary payload types
package pipe_pkg;

  // Occupancy of a pipeline boundary register
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } stage_state_e;

  // addi x0, x0, 0 : the canonical RISC-V no-op used as an instruction bubble
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // IF/ID boundary payload
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
  } if_id_t;

  // ID/EX boundary payload
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
  } id_ex_t;

  // EX/MEM boundary payload
  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
  } ex_mem_t;

  // MEM/WB boundary payload
  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        wb_en;
  } mem_wb_t;

endpackage

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - pipeline boundary register with valid/ready, flush and optional skid
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       SKID_EN    = 1,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  if (SKID_EN != 0) begin : g_skid
    stage_state_e      state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              ready_q;

    // Next state and register contents; M always drains before S so order is kept
    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
        EMPTY: begin
          if (in_valid) begin
            state_d = FULL;
            main_d  = in_data;
          end
        end
        FULL: begin
          if (out_ready) begin
            if (in_valid) begin
              main_d = in_data;
            end else begin
              state_d = EMPTY;
              main_d  = BUBBLE_VAL;
            end
          end else if (in_valid) begin
            state_d = SKID;
            skid_d  = in_data;
          end
        end
        SKID: begin
          if (out_ready) begin
            state_d = FULL;
            main_d  = skid_q;
            skid_d  = BUBBLE_VAL;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE_VAL;
          skid_d  = BUBBLE_VAL;
        end
      endcase
      if (flush) begin
        state_d = EMPTY;
        main_d  = BUBBLE_VAL;
        skid_d  = BUBBLE_VAL;
      end
    end

    // State and data registers; in_ready is precomputed so it leaves the stage as a flop
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= EMPTY;
        main_q  <= BUBBLE_VAL;
        skid_q  <= BUBBLE_VAL;
        ready_q <= 1'b1;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
        ready_q <= (state_d != SKID);
      end
    end

    assign in_ready  = ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
  end else begin : g_single
    logic              valid_q;
    logic [DATA_W-1:0] main_q;

    // Single entry: load on input transfer, fall back to the bubble on drain without refill
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        valid_q <= 1'b0;
        main_q  <= BUBBLE_VAL;
      end else if (in_valid && in_ready) begin
        valid_q <= 1'b1;
        main_q  <= in_data;
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
        main_q  <= BUBBLE_VAL;
      end
    end

    assign in_ready  = out_ready | ~valid_q;
    assign out_valid = valid_q;
    assign out_data  = main_q;
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - checks both stage variants against a queue-based occupancy model
module tb_pipe_skid_stage;
  import pipe_pkg::*;

  localparam int          DW     = $bits(if_id_t);
  localparam logic [DW-1:0] BUBBLE = {64'd0, INST_NOP};

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready_w  [2];
  logic          out_valid_w [2];
  logic [DW-1:0] out_data_w  [2];

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  localparam logic [DW-1:0] VA = {32'h0000_1000, 32'h0000_1004, 32'h00A0_0093};
  localparam logic [DW-1:0] VB = {32'h0000_1004, 32'h0000_1008, 32'h00B0_0113};
  localparam logic [DW-1:0] VC = {32'h0000_1008, 32'h0000_100C, 32'h00C0_0193};
  localparam logic [DW-1:0] VD = {32'hDEAD_0000, 32'hDEAD_0004, 32'hDEAD_BEEF};

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(DW), .SKID_EN(0), .BUBBLE_VAL(BUBBLE)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_w[0]), .in_data(in_data),
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_data(out_data_w[0])
  );

  pipe_skid_stage #(.DATA_W(DW), .SKID_EN(1), .BUBBLE_VAL(BUBBLE)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_w[1]), .in_data(in_data),
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_data(out_data_w[1])
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: variant 0 holds one entry with pass-through ready, variant 1 holds two with ready = not full
  always @(posedge clk) begin : model
    bit r0, r1;
    r0 = (q0.size() == 0) || out_ready;
    r1 = (q1.size() < 2);
    if (rst || flush) begin
      q0.delete();
      q1.delete();
    end else begin
      if (q0.size() != 0 && out_ready) void'(q0.pop_front());
      if (in_valid && r0) q0.push_back(in_data);
      if (q1.size() != 0 && out_ready) void'(q1.pop_front());
      if (in_valid && r1) q1.push_back(in_data);
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("m0_valid", {95'd0, out_valid_w[0]}, {95'd0, q0.size() != 0});
      check("m0_data",  out_data_w[0], (q0.size() != 0) ? q0[0] : BUBBLE);
      check("m0_ready", {95'd0, in_ready_w[0]}, {95'd0, (q0.size() == 0) || out_ready});
      check("m1_valid", {95'd0, out_valid_w[1]}, {95'd0, q1.size() != 0});
      check("m1_data",  out_data_w[1], (q1.size() != 0) ? q1[0] : BUBBLE);
      check("m1_ready", {95'd0, in_ready_w[1]}, {95'd0, q1.size() < 2});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  task automatic check_idle(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({tag, "_valid"}, {95'd0, out_valid_w[k]}, '0);
      check({tag, "_data"},  out_data_w[k], BUBBLE);
      check({tag, "_ready"}, {95'd0, in_ready_w[k]}, {95'd0, 1'b1});
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    step();
    chk_en = 1'b1;
    rst    = 1'b0;

    // Idle after reset
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle("reset_idle");
    end

    // Back-to-back stream with downstream always ready
    drive(1'b1, VA, 1'b1, 1'b0); step();
    check("stream_a0", out_data_w[0], VA);
    check("stream_a1", out_data_w[1], VA);
    drive(1'b1, VB, 1'b1, 1'b0); step();
    check("stream_b0", out_data_w[0], VB);
    check("stream_b1", out_data_w[1], VB);
    drive(1'b1, VC, 1'b1, 1'b0); step();
    check("stream_c0", out_data_w[0], VC);
    check("stream_c1", out_data_w[1], VC);
    check("stream_c_valid1", {95'd0, out_valid_w[1]}, {95'd0, 1'b1});
    drive(1'b0, '0, 1'b1, 1'b0); step();
    check_idle("stream_drain");

    // Stall with a second entry landing in the skid register
    drive(1'b1, VA, 1'b0, 1'b0); step();
    check("stall_a1", out_data_w[1], VA);
    check("stall_ready1", {95'd0, in_ready_w[1]}, {95'd0, 1'b1});
    check("stall_ready0", {95'd0, in_ready_w[0]}, '0);
    drive(1'b1, VB, 1'b0, 1'b0); step();
    check("skid_ready1", {95'd0, in_ready_w[1]}, '0);
    check("skid_hold1", out_data_w[1], VA);
    check("skid_hold0", out_data_w[0], VA);
    drive(1'b0, '0, 1'b1, 1'b0); step();
    check("skid_b1", out_data_w[1], VB);
    check("skid_b_ready1", {95'd0, in_ready_w[1]}, {95'd0, 1'b1});
    step();
    check("skid_empty1", {95'd0, out_valid_w[1]}, '0);

    // Flush while the skid register is occupied and a new input is offered
    drive(1'b1, VA, 1'b0, 1'b0); step();
    drive(1'b1, VB, 1'b0, 1'b0); step();
    drive(1'b1, VD, 1'b0, 1'b1); step();
    check_idle("flush");
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_no_d1", {95'd0, out_valid_w[1]}, '0);
    end

    // Reset mid-stream with two entries held
    drive(1'b1, VA, 1'b0, 1'b0); step();
    drive(1'b1, VB, 1'b0, 1'b0); step();
    drive(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle("mid_rst");
    end

    // Reset and flush together
    drive(1'b1, VC, 1'b0, 1'b0); step();
    drive(1'b1, VD, 1'b0, 1'b0); step();
    drive(1'b1, VA, 1'b0, 1'b1);
    rst = 1'b1; step(); rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    check_idle("rst_flush");

    // Random traffic against the model, with occasional flushes
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom},
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0));
      step();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    step();
    step();
    check_idle("final_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
